// File: rtl/lcd_i2c_writer.sv
`default_nettype none
// =====================================================================
// Module   : lcd_i2c_writer
// Purpose  : Streams two 16-character rows to an HD44780 LCD through a
//            PCF8574 expander (4-bit mode), including power-on init.
// Revision : 1.0 - initial release
// =====================================================================
module lcd_i2c_writer #(
    parameter int unsigned PWR_WAIT_CYC = 750000,
    parameter int unsigned CMD_WAIT_CYC = 2500,
    parameter int unsigned CLR_WAIT_CYC = 100000,
    parameter bit          BACKLIGHT    = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] row1,
    input  logic [127:0] row2,
    input  logic         refresh,
    output logic [7:0]   i2c_data,
    output logic         i2c_valid,
    input  logic         i2c_ready,
    output logic         init_done,
    output logic         busy,
    output logic         frame_done
);
    localparam int unsigned c_max_a    = (PWR_WAIT_CYC > CMD_WAIT_CYC) ? PWR_WAIT_CYC : CMD_WAIT_CYC;
    localparam int unsigned c_max_wait = (c_max_a > CLR_WAIT_CYC) ? c_max_a : CLR_WAIT_CYC;
    localparam int          c_cnt_w    = $clog2(c_max_wait + 1);
    localparam logic [c_cnt_w-1:0] c_pwr_last = c_cnt_w'(PWR_WAIT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cmd_last = c_cnt_w'(CMD_WAIT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_clr_last = c_cnt_w'(CLR_WAIT_CYC - 1);

    localparam logic [2:0] c_st_pwr_wait = 3'd0;
    localparam logic [2:0] c_st_init     = 3'd1;
    localparam logic [2:0] c_st_idle     = 3'd2;
    localparam logic [2:0] c_st_addr1    = 3'd3;
    localparam logic [2:0] c_st_chars1   = 3'd4;
    localparam logic [2:0] c_st_addr2    = 3'd5;
    localparam logic [2:0] c_st_chars2   = 3'd6;
    localparam logic [2:0] c_st_done     = 3'd7;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_in_gap;
    logic [1:0]         r_byte_idx;
    logic               r_valid;
    logic [7:0]         r_data;
    logic [2:0]         r_step;
    logic [3:0]         r_char_idx;
    logic [127:0]       r_snap1;
    logic [127:0]       r_snap2;
    logic               r_pending;
    logic               r_init_done;

    logic [2:0]         w_state_next;
    logic               w_sending;
    logic               w_nib_only;
    logic [7:0]         w_lcd_byte;
    logic               w_rs;
    logic [c_cnt_w-1:0] w_gap_last;
    logic               w_item_done;
    logic               w_changed;
    logic               w_start;
    logic [1:0]         w_last_idx;
    logic [3:0]         w_nib;
    logic [7:0]         w_tx_byte;

    always_comb begin
        w_sending    = 1'b0;
        w_nib_only   = 1'b0;
        w_lcd_byte   = 8'h00;
        w_rs         = 1'b0;
        w_gap_last   = c_cmd_last;
        w_start      = 1'b0;
        w_state_next = r_state;
        case (r_state)
            c_st_init: begin
                w_sending  = 1'b1;
                w_nib_only = ~r_step[2];
                case (r_step)
                    3'd0, 3'd1, 3'd2: w_lcd_byte = 8'h30;
                    3'd3:             w_lcd_byte = 8'h20;
                    3'd4:             w_lcd_byte = 8'h28;
                    3'd5:             w_lcd_byte = 8'h0C;
                    3'd6:             w_lcd_byte = 8'h06;
                    default:          w_lcd_byte = 8'h01;
                endcase
                if (r_step == 3'd7) w_gap_last = c_clr_last;
            end
            c_st_addr1: begin
                w_sending  = 1'b1;
                w_lcd_byte = 8'h80;
            end
            c_st_chars1: begin
                w_sending  = 1'b1;
                w_rs       = 1'b1;
                w_lcd_byte = r_snap1[{~r_char_idx, 3'b000} +: 8];
            end
            c_st_addr2: begin
                w_sending  = 1'b1;
                w_lcd_byte = 8'hC0;
            end
            c_st_chars2: begin
                w_sending  = 1'b1;
                w_rs       = 1'b1;
                w_lcd_byte = r_snap2[{~r_char_idx, 3'b000} +: 8];
            end
            default: ;
        endcase

        w_item_done = w_sending && r_in_gap && (r_cnt == w_gap_last);
        w_changed   = (row1 != r_snap1) || (row2 != r_snap2);

        case (r_state)
            c_st_pwr_wait: if (r_cnt == c_pwr_last) w_state_next = c_st_init;
            c_st_init:     if (w_item_done && r_step == 3'd7) w_state_next = c_st_idle;
            c_st_idle: begin
                if (r_pending || refresh || w_changed) begin
                    w_start      = 1'b1;
                    w_state_next = c_st_addr1;
                end
            end
            c_st_addr1:    if (w_item_done) w_state_next = c_st_chars1;
            c_st_chars1:   if (w_item_done && r_char_idx == 4'd15) w_state_next = c_st_addr2;
            c_st_addr2:    if (w_item_done) w_state_next = c_st_chars2;
            c_st_chars2:   if (w_item_done && r_char_idx == 4'd15) w_state_next = c_st_done;
            c_st_done:     w_state_next = c_st_idle;
            default:       w_state_next = c_st_pwr_wait;
        endcase
    end

    // Nibble-only init items send two expander bytes, full LCD bytes four.
    assign w_last_idx = w_nib_only ? 2'd1 : 2'd3;
    assign w_nib      = r_byte_idx[1] ? w_lcd_byte[3:0] : w_lcd_byte[7:4];
    assign w_tx_byte  = {w_nib, BACKLIGHT, ~r_byte_idx[0], 1'b0, w_rs};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_pwr_wait;
            r_cnt       <= '0;
            r_in_gap    <= 1'b0;
            r_byte_idx  <= 2'd0;
            r_valid     <= 1'b0;
            r_data      <= 8'h00;
            r_step      <= 3'd0;
            r_char_idx  <= 4'd0;
            r_snap1     <= '0;
            r_snap2     <= '0;
            r_pending   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (refresh && r_state != c_st_idle) r_pending <= 1'b1;
            if (w_start) begin
                r_snap1   <= row1;
                r_snap2   <= row2;
                r_pending <= 1'b0;
            end
            if (r_state == c_st_pwr_wait) begin
                r_cnt <= (w_state_next == c_st_pwr_wait) ? r_cnt + c_cnt_w'(1) : '0;
            end
            if (w_sending) begin
                if (!r_in_gap) begin
                    // A byte is presented only from a cycle with valid low,
                    // guaranteeing the idle cycle after every accept.
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_data  <= w_tx_byte;
                    end else if (i2c_ready) begin
                        r_valid <= 1'b0;
                        if (r_byte_idx == w_last_idx) begin
                            r_in_gap <= 1'b1;
                            r_cnt    <= '0;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                end else if (w_item_done) begin
                    r_in_gap   <= 1'b0;
                    r_byte_idx <= 2'd0;
                    r_cnt      <= '0;
                    if (r_state == c_st_init) begin
                        r_step <= r_step + 3'd1;
                        if (r_step == 3'd7) begin
                            r_init_done <= 1'b1;
                            r_pending   <= 1'b1;
                        end
                    end else if (r_state == c_st_chars1 || r_state == c_st_chars2) begin
                        r_char_idx <= r_char_idx + 4'd1;
                    end
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end
        end
    end

    assign i2c_data   = r_data;
    assign i2c_valid  = r_valid;
    assign init_done  = r_init_done;
    assign busy       = (r_state != c_st_idle);
    assign frame_done = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_lcd_i2c_writer.sv
`default_nettype none
// =====================================================================
// Module   : tb_lcd_i2c_writer
// Purpose  : Randomized self-checking bench for lcd_i2c_writer against a
//            byte-stream reference model.
// Revision : 1.0 - initial release
// =====================================================================
module tb_lcd_i2c_writer;
    localparam int unsigned PWR = 10;
    localparam int unsigned CMD = 3;
    localparam int unsigned CLR = 5;
    localparam int          c_open = 100000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] row1 = '0;
    logic [127:0] row2 = '0;
    logic         refresh = 1'b0;
    logic [7:0]   i2c_data;
    logic         i2c_valid;
    logic         i2c_ready = 1'b0;
    logic         init_done;
    logic         busy;
    logic         frame_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lcd_i2c_writer #(
        .PWR_WAIT_CYC (PWR),
        .CMD_WAIT_CYC (CMD),
        .CLR_WAIT_CYC (CLR),
        .BACKLIGHT    (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row1       (row1),
        .row2       (row2),
        .refresh    (refresh),
        .i2c_data   (i2c_data),
        .i2c_valid  (i2c_valid),
        .i2c_ready  (i2c_ready),
        .init_done  (init_done),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         cyc = 0;
    int         rst_cyc = 0;
    int         initd_cyc = -1;
    int         fd_cnt = 0;
    logic       fd_prev = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_acc = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            rst_cyc    = cyc;
            initd_cyc  = -1;
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
            fd_prev    = 1'b0;
        end else begin
            if (prev_acc) begin
                check("valid_drop", i2c_valid, 1'b0);
            end else if (prev_valid) begin
                check("hold_valid", i2c_valid, 1'b1);
                check("hold_data", i2c_data, prev_data);
            end
            if (i2c_valid && i2c_ready) begin
                got_q.push_back(i2c_data);
                got_cyc.push_back(cyc);
            end
            if (frame_done) begin
                check("fd_pulse", fd_prev, 1'b0);
                fd_cnt++;
            end
            if (init_done && initd_cyc < 0) initd_cyc = cyc;
            prev_valid = i2c_valid;
            prev_acc   = i2c_valid && i2c_ready;
            prev_data  = i2c_data;
            fd_prev    = frame_done;
        end
    end

    // 0: always ready, 1: random ready, 2: held low
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       i2c_ready = 1'b1;
            1:       i2c_ready = ($urandom_range(0, 3) != 0);
            default: i2c_ready = 1'b0;
        endcase
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    int         exp_lo[$];
    int         exp_hi[$];

    task automatic add_nib(input logic [3:0] n, input logic rs);
        exp_q.push_back({n, 1'b1, 1'b1, 1'b0, rs});
        exp_lo.push_back(2); exp_hi.push_back(3);
        exp_q.push_back({n, 1'b1, 1'b0, 1'b0, rs});
        exp_lo.push_back(2); exp_hi.push_back(3);
    endtask

    task automatic add_byte(input logic [7:0] b, input logic rs);
        add_nib(b[7:4], rs);
        add_nib(b[3:0], rs);
    endtask

    task automatic end_item(input int lo, input int hi);
        exp_lo[exp_lo.size()-1] = lo;
        exp_hi[exp_hi.size()-1] = hi;
    endtask

    task automatic add_init();
        logic [3:0] nibs [4];
        logic [7:0] cmds [4];
        nibs = '{4'h3, 4'h3, 4'h3, 4'h2};
        cmds = '{8'h28, 8'h0C, 8'h06, 8'h01};
        for (int i = 0; i < 4; i++) begin
            add_nib(nibs[i], 1'b0);
            end_item(CMD + 1, CMD + 3);
        end
        for (int i = 0; i < 4; i++) begin
            add_byte(cmds[i], 1'b0);
            if (i == 3) end_item(CLR + 1, c_open);
            else        end_item(CMD + 1, CMD + 3);
        end
    endtask

    task automatic add_frame(input logic [127:0] r1, input logic [127:0] r2);
        add_byte(8'h80, 1'b0);
        end_item(CMD + 1, CMD + 3);
        for (int i = 0; i < 16; i++) begin
            add_byte(r1[127-8*i -: 8], 1'b1);
            end_item(CMD + 1, CMD + 3);
        end
        add_byte(8'hC0, 1'b0);
        end_item(CMD + 1, CMD + 3);
        for (int i = 0; i < 16; i++) begin
            add_byte(r2[127-8*i -: 8], 1'b1);
            end_item(CMD + 1, (i == 15) ? c_open : CMD + 3);
        end
    endtask

    function automatic logic [127:0] rand_row();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 7) == 0) r[8*i +: 8] = 8'h00;
            else                           r[8*i +: 8] = 8'($urandom_range(32, 126));
        end
        return r;
    endfunction

    task automatic clear_all();
        got_q.delete(); got_cyc.delete();
        exp_q.delete(); exp_lo.delete(); exp_hi.delete();
    endtask

    task automatic compare_stream(input string tag, input bit strict);
        int n;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
            if (got_q[i] !== exp_q[i]) break;
        end
        if (strict) begin
            for (int i = 1; i < n; i++) begin
                int  d;
                logic ok;
                d  = got_cyc[i] - got_cyc[i-1];
                ok = (d >= exp_lo[i-1]) && (d <= exp_hi[i-1]);
                check($sformatf("%s_spacing%0d_d%0d", tag, i, d), ok, 1'b1);
                if (!ok) break;
            end
        end
        clear_all();
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin @(negedge clk); k++; end
        check({tag, "_bytes_timeout"}, (k < budget), 1'b1);
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while ((fd_cnt < target || busy) && k < budget) begin @(negedge clk); k++; end
        check({tag, "_frame_timeout"}, (k < budget), 1'b1);
        repeat (30) @(negedge clk);
    endtask

    task automatic check_init_timing(input string tag);
        int d;
        if (got_cyc.size() > 0) begin
            d = got_cyc[0] - rst_cyc;
            check($sformatf("%s_pwr_wait_d%0d", tag, d), (d >= PWR + 1) && (d <= PWR + 4), 1'b1);
        end
        if (got_cyc.size() >= 24) begin
            d = initd_cyc - got_cyc[23];
            check($sformatf("%s_init_done_d%0d", tag, d), (initd_cyc > 0) && (d >= CLR + 1) && (d <= CLR + 2), 1'b1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int           base;
        int           k;
        int           c0;
        logic [7:0]   d0;
        logic [127:0] r1;
        logic [127:0] r2_old;
        logic [127:0] r2_new;

        row1 = {8'h41, {15{8'h20}}};
        row2 = rand_row();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", i2c_valid, 1'b0);
        check("rst_data", i2c_data, 8'h00);
        check("rst_init_done", init_done, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_frame_done", frame_done, 1'b0);

        // init plus first frame
        clear_all();
        add_init();
        add_frame(row1, row2);
        @(posedge clk); #1 rst = 1'b0;
        wait_frames(1, 5000, "first");
        check("first_frames", fd_cnt, 1);
        check("first_busy", busy, 1'b0);
        check("first_init_done", init_done, 1'b1);
        check_init_timing("first");
        compare_stream("first", 1'b1);

        // random backpressure with a 10-cycle stall
        base = fd_cnt;
        ready_mode = 1;
        row1 = rand_row();
        row2 = rand_row();
        add_frame(row1, row2);
        wait_bytes(30, 3000, "bp");
        ready_mode = 2;
        @(posedge clk);
        @(negedge clk);
        k = 0;
        while (!i2c_valid && k < 20) begin @(negedge clk); k++; end
        check("bp_valid", i2c_valid, 1'b1);
        d0 = i2c_data;
        c0 = got_q.size();
        repeat (10) begin
            @(negedge clk);
            check("bp_data_stable", i2c_data, d0);
            check("bp_count_stable", got_q.size(), c0);
        end
        ready_mode = 1;
        wait_frames(base + 1, 8000, "bp");
        check("bp_frames", fd_cnt - base, 1);
        compare_stream("bp", 1'b0);

        // row2 change during CHARS1
        ready_mode = 0;
        base = fd_cnt;
        r1 = rand_row();
        r2_old = row2;
        row1 = r1;
        add_frame(r1, r2_old);
        wait_bytes(40, 3000, "mid");
        r2_new = rand_row();
        while (r2_new == r2_old) r2_new = rand_row();
        row2 = r2_new;
        add_frame(r1, r2_new);
        wait_frames(base + 2, 8000, "mid");
        check("mid_frames", fd_cnt - base, 2);
        compare_stream("mid", 1'b1);

        // refresh while idle, then two refresh pulses while busy
        base = fd_cnt;
        add_frame(row1, row2);
        add_frame(row1, row2);
        @(posedge clk); #1 refresh = 1'b1;
        @(posedge clk); #1 refresh = 1'b0;
        k = 0;
        while (!busy && k < 2) begin @(negedge clk); k++; end
        check("refresh_idle_start", busy, 1'b1);
        wait_bytes(20, 3000, "refresh");
        @(posedge clk); #1 refresh = 1'b1;
        @(posedge clk); #1 refresh = 1'b0;
        repeat (7) @(posedge clk);
        #1 refresh = 1'b1;
        @(posedge clk); #1 refresh = 1'b0;
        wait_frames(base + 2, 8000, "refresh");
        check("refresh_frames", fd_cnt - base, 2);
        compare_stream("refresh", 1'b1);

        // reset in the middle of a frame
        row1 = rand_row();
        wait_bytes(50, 3000, "rstmid");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_valid", i2c_valid, 1'b0);
        check("rstmid_init_done", init_done, 1'b0);
        check("rstmid_busy", busy, 1'b1);
        check("rstmid_frame_done", frame_done, 1'b0);
        clear_all();
        add_init();
        add_frame(row1, row2);
        base = fd_cnt;
        @(posedge clk); #1 rst = 1'b0;
        wait_frames(base + 1, 5000, "rstmid");
        check("rstmid_frames", fd_cnt - base, 1);
        check_init_timing("rstmid");
        compare_stream("rstmid", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
